// File: rtl/dnn2ami_write_path_pkg.sv
// dnn2ami_write_path shared definitions:
// AMI request field layout, macro entry layout, FSM states.
package dnn2ami_write_path_pkg;

  localparam int BEAT_BYTES = 8;
  localparam int TS_W       = 64;

  // AMI request, MSB..LSB: valid, isWrite, addr(64), data(DW), size(8)
  localparam int REQ_SIZE_W   = 8;
  localparam int REQ_ADDR_W   = 64;
  localparam int REQ_META_W   = 2 + REQ_ADDR_W + REQ_SIZE_W;
  localparam int REQ_SIZE_LSB = 0;
  localparam int REQ_DATA_LSB = REQ_SIZE_LSB + REQ_SIZE_W;

  function automatic int req_w(input int dw);
    return REQ_META_W + dw;
  endfunction

  function automatic int req_addr_lsb(input int dw);
    return REQ_DATA_LSB + dw;
  endfunction

  function automatic int req_wr_bit(input int dw);
    return req_addr_lsb(dw) + REQ_ADDR_W;
  endfunction

  function automatic int req_valid_bit(input int dw);
    return req_wr_bit(dw) + 1;
  endfunction

  // Macro entry, MSB..LSB: addr, size, pu_id, timestamp
  localparam int MAC_TS_LSB = 0;
  localparam int MAC_PU_LSB = MAC_TS_LSB + TS_W;

  function automatic int mac_sz_lsb(input int pw);
    return MAC_PU_LSB + pw;
  endfunction

  function automatic int mac_ad_lsb(input int pw, input int sw);
    return mac_sz_lsb(pw) + sw;
  endfunction

  function automatic int mac_w(input int aw, input int sw, input int pw);
    return mac_ad_lsb(pw, sw) + aw;
  endfunction

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } wp_state_e;

endpackage

// File: rtl/dnn2ami_write_path_sync_fifo.sv
// Show-ahead synchronous FIFO; head data valid whenever not empty.
// Writes while full are rejected even with a concurrent read.
module dnn2ami_write_path_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q;
  logic [LOG_DEPTH-1:0] rd_ptr_q;
  logic [LOG_DEPTH:0]   cnt_q;
  logic                 wr_ok;
  logic                 rd_ok;

  assign full_o    = cnt_q == (LOG_DEPTH+1)'(DEPTH);
  assign empty_o   = cnt_q == '0;
  assign wr_ok     = wr_en_i && !full_o;
  assign rd_ok     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_ok && !rd_ok)
        cnt_q <= cnt_q + 1'b1;
      else if (rd_ok && !wr_ok)
        cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/dnn2ami_write_path.sv
// Write-path adapter: queues macro write requests and fractures
// them into 8-byte AMI write requests fed from the PU output buffers.
module dnn2ami_write_path
  import dnn2ami_write_path_pkg::*;
#(
  parameter int NUM_PU            = 2,
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int AXI_DATA_WIDTH    = 64,
  parameter int TX_SIZE_WIDTH     = 10,
  parameter int NUM_PU_W          = $clog2(NUM_PU) + 1,
  parameter int MACRO_Q_LOG_DEPTH = 3,
  parameter int REQ_Q_LOG_DEPTH   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_req,
  input  logic [NUM_PU_W-1:0]              wr_pu_id,
  input  logic [TX_SIZE_WIDTH-1:0]         wr_req_size,
  input  logic [AXI_ADDR_WIDTH-1:0]        wr_addr,
  output logic                             wr_ready,
  output logic                             wr_done,
  input  logic [NUM_PU-1:0]                outbuf_empty,
  input  logic [NUM_PU*AXI_DATA_WIDTH-1:0] data_from_outbuf,
  input  logic [NUM_PU-1:0]                write_valid,
  output logic [NUM_PU-1:0]                outbuf_pop,
  output logic                             reqValid,
  input  logic                             reqOut_grant,
  output logic [req_w(AXI_DATA_WIDTH)-1:0] reqOut
);

  localparam int AW  = AXI_ADDR_WIDTH;
  localparam int DW  = AXI_DATA_WIDTH;
  localparam int SW  = TX_SIZE_WIDTH;
  localparam int PW  = NUM_PU_W;
  localparam int RW  = req_w(DW);
  localparam int MW  = mac_w(AW, SW, PW);
  localparam int VB  = req_valid_bit(DW);
  localparam int MSZ = mac_sz_lsb(PW);
  localparam int MAD = mac_ad_lsb(PW, SW);

  logic [TS_W-1:0] ts_q;

  logic          mq_rd;
  logic [MW-1:0] mq_din;
  logic [MW-1:0] mq_dout;
  logic          mq_full;
  logic          mq_empty;

  logic          rq_wr;
  logic          rq_rd;
  logic [RW-1:0] rq_din;
  logic [RW-1:0] rq_dout;
  logic          rq_full;
  logic          rq_empty;

  wp_state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pu_q, pu_d;
  logic          done_q, done_d;

  logic          pu_empty;
  logic [DW-1:0] pu_data;
  logic          issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end

  assign mq_din = {wr_addr, wr_req_size, wr_pu_id, ts_q};

  dnn2ami_write_path_sync_fifo #(
    .WIDTH     (MW),
    .LOG_DEPTH (MACRO_Q_LOG_DEPTH)
  ) u_macro_q (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_req),
    .wr_data_i (mq_din),
    .rd_en_i   (mq_rd),
    .rd_data_o (mq_dout),
    .full_o    (mq_full),
    .empty_o   (mq_empty)
  );

  // An out-of-range PU id reads as an empty buffer.
  always_comb begin
    pu_empty = 1'b1;
    pu_data  = '0;
    for (int p = 0; p < NUM_PU; p++) begin
      if (pu_q == PW'(p)) begin
        pu_empty = outbuf_empty[p];
        pu_data  = data_from_outbuf[p*DW +: DW];
      end
    end
  end

  assign issue = (state_q == ST_ACTIVE) && (cnt_q != '0)
              && !pu_empty && !rq_full;

  always_comb begin
    outbuf_pop = '0;
    for (int p = 0; p < NUM_PU; p++) begin
      outbuf_pop[p] = issue && (pu_q == PW'(p));
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    pu_d    = pu_q;
    done_d  = 1'b0;
    mq_rd   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!mq_empty) begin
          mq_rd   = 1'b1;
          addr_d  = mq_dout[MAD +: AW];
          cnt_d   = mq_dout[MSZ +: SW];
          pu_d    = mq_dout[MAC_PU_LSB +: PW];
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (issue) begin
          addr_d = addr_q + AW'(BEAT_BYTES);
          cnt_d  = cnt_q - SW'(1);
        end
        if (cnt_d == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      pu_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pu_q    <= pu_d;
      done_q  <= done_d;
    end
  end

  assign rq_wr  = issue;
  assign rq_din = {1'b1, 1'b1, REQ_ADDR_W'(addr_q), pu_data,
                   REQ_SIZE_W'(BEAT_BYTES)};
  assign rq_rd  = reqValid && reqOut_grant;

  dnn2ami_write_path_sync_fifo #(
    .WIDTH     (RW),
    .LOG_DEPTH (REQ_Q_LOG_DEPTH)
  ) u_req_q (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (rq_wr),
    .wr_data_i (rq_din),
    .rd_en_i   (rq_rd),
    .rd_data_o (rq_dout),
    .full_o    (rq_full),
    .empty_o   (rq_empty)
  );

  assign reqValid = !rq_empty && rq_dout[VB];
  assign reqOut   = rq_empty ? '0 : rq_dout;
  assign wr_ready = mq_empty && (state_q == ST_IDLE) && rq_empty;
  assign wr_done  = done_q;

  logic unused_ok;
  assign unused_ok = ^{write_valid, mq_full, mq_dout[MAC_TS_LSB +: TS_W]};

endmodule

// File: tb/tb_dnn2ami_write_path.sv
// Randomized bench for dnn2ami_write_path against a queue-based
// model of expected AMI writes and per-PU buffer streams.
module tb_dnn2ami_write_path;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 10;
  localparam int PW = 2;
  localparam int RW = 74 + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_req;
  logic [PW-1:0]   wr_pu_id;
  logic [SW-1:0]   wr_req_size;
  logic [AW-1:0]   wr_addr;
  logic            wr_ready;
  logic            wr_done;
  logic [NP-1:0]   outbuf_empty;
  logic [NP*DW-1:0] data_from_outbuf;
  logic [NP-1:0]   write_valid;
  logic [NP-1:0]   outbuf_pop;
  logic            reqValid;
  logic            reqOut_grant;
  logic [RW-1:0]   reqOut;

  always #5 clk = ~clk;

  dnn2ami_write_path dut (
    .clk              (clk),
    .rst              (rst),
    .wr_req           (wr_req),
    .wr_pu_id         (wr_pu_id),
    .wr_req_size      (wr_req_size),
    .wr_addr          (wr_addr),
    .wr_ready         (wr_ready),
    .wr_done          (wr_done),
    .outbuf_empty     (outbuf_empty),
    .data_from_outbuf (data_from_outbuf),
    .write_valid      (write_valid),
    .outbuf_pop       (outbuf_pop),
    .reqValid         (reqValid),
    .reqOut_grant     (reqOut_grant),
    .reqOut           (reqOut)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [RW-1:0] got,
                     input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: per-PU data streams, expected AMI writes in order.
  logic [DW-1:0] strm [NP][$];
  int            rdp [NP];
  int            alloc [NP];
  logic [RW-1:0] expq [$];
  int            exp_done = 0;

  int            cyc = 0;
  int            done_seen = 0;
  int            pops_seen = 0;
  int            pops_pu [NP];
  int            valids_seen = 0;
  int            first_pop = -1;
  int            first_val = -1;
  int            last_pop = -1;
  int            done_cyc = -1;
  int            sub_cyc = 0;
  logic          rdy_obs = 1'b1;

  logic [NP-1:0] stall = '0;
  logic          grant = 1'b1;
  logic          rnd_mode = 1'b0;
  logic          req_pend = 1'b0;
  int            rq_pu = 0;
  logic [AW-1:0] rq_addr = '0;
  int            rq_size = 0;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rnd_mode) begin
      grant = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NP; p++) stall[p] = ($urandom_range(0, 4) == 0);
    end
    wr_req       = req_pend;
    wr_pu_id     = PW'(rq_pu);
    wr_addr      = rq_addr;
    wr_req_size  = SW'(rq_size);
    reqOut_grant = grant;
    write_valid  = NP'($urandom);
    for (int p = 0; p < NP; p++) begin
      if (!stall[p] && rdp[p] < strm[p].size()) begin
        outbuf_empty[p] = 1'b0;
        data_from_outbuf[p*DW +: DW] = strm[p][rdp[p]];
      end else begin
        outbuf_empty[p] = 1'b1;
        data_from_outbuf[p*DW +: DW] = {$urandom, $urandom};
      end
    end
    #1;
    if (outbuf_pop != '0) begin
      chk("pop_onehot", RW'($onehot(outbuf_pop)), RW'(1));
      chk("pop_on_empty", RW'(outbuf_pop & outbuf_empty), '0);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    for (int p = 0; p < NP; p++) begin
      if (outbuf_pop[p]) begin
        rdp[p]++;
        pops_seen++;
        pops_pu[p]++;
      end
    end
    if (reqValid) begin
      if (first_val < 0) first_val = cyc;
    end
    if (reqValid && reqOut_grant) begin
      valids_seen++;
      if (expq.size() == 0) chk("req_unexpected", reqOut, '0);
      else                  chk("req", reqOut, expq.pop_front());
    end
    if (wr_done) begin
      done_seen++;
      done_cyc = cyc;
    end
    rdy_obs = wr_ready;
  endtask

  task automatic submit(input int pu, input logic [AW-1:0] addr,
                        input int size);
    for (int k = 0; k < size; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = addr + AW'(8 * k);
      while (strm[pu].size() <= alloc[pu])
        strm[pu].push_back({$urandom, $urandom});
      d = strm[pu][alloc[pu]];
      alloc[pu]++;
      expq.push_back({1'b1, 1'b1, 32'h0, a, d, 8'd8});
    end
    exp_done++;
    rq_pu    = pu;
    rq_addr  = addr;
    rq_size  = size;
    req_pend = 1'b1;
    tick();
    req_pend = 1'b0;
    sub_cyc  = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(expq.size() == 0 && done_seen == exp_done && rdy_obs)
           && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, RW'(n < 2000), RW'(1));
    chk({tag, "_done"}, RW'(done_seen), RW'(exp_done));
    chk({tag, "_ready"}, RW'(rdy_obs), RW'(1));
    tick();
    tick();
    chk({tag, "_done_extra"}, RW'(done_seen), RW'(exp_done));
  endtask

  task automatic clr_stats();
    pops_seen   = 0;
    valids_seen = 0;
    first_pop   = -1;
    first_val   = -1;
    last_pop    = -1;
    done_cyc    = -1;
    for (int p = 0; p < NP; p++) pops_pu[p] = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_reqValid"}, RW'(reqValid), '0);
    chk({tag, "_wr_done"}, RW'(wr_done), '0);
    chk({tag, "_pop"}, RW'(outbuf_pop), '0);
    chk({tag, "_wr_ready"}, RW'(wr_ready), RW'(1));
    chk({tag, "_reqOut"}, reqOut, '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    for (int p = 0; p < NP; p++) begin
      rdp[p] = 0;
      alloc[p] = 0;
      pops_pu[p] = 0;
    end
    rst = 1'b1;
    wr_req = 1'b0;
    wr_pu_id = '0;
    wr_req_size = '0;
    wr_addr = '0;
    outbuf_empty = '1;
    data_from_outbuf = '0;
    write_valid = '0;
    reqOut_grant = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs("rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    chk_reset_outs("idle");

    // Single request, latency and done timing
    clr_stats();
    submit(1, 32'h1000, 3);
    wait_idle("single");
    chk("single_pops_pu1", RW'(pops_pu[1]), RW'(3));
    chk("single_pops_pu0", RW'(pops_pu[0]), '0);
    chk("lat_pop", RW'(first_pop), RW'(sub_cyc + 2));
    chk("lat_valid", RW'(first_val), RW'(sub_cyc + 3));
    chk("done_lat", RW'(done_cyc), RW'(last_pop + 1));

    // Buffer stall mid-transfer
    clr_stats();
    submit(0, 32'h2000, 6);
    repeat (3) tick();
    chk("stall_pre", RW'(pops_seen), RW'(2));
    stall[0] = 1'b1;
    p0 = pops_seen;
    repeat (5) tick();
    chk("stall_nopop", RW'(pops_seen - p0), '0);
    stall[0] = 1'b0;
    wait_idle("stall");

    // Request-queue backpressure
    clr_stats();
    grant = 1'b0;
    submit(0, 32'h3000, 12);
    repeat (20) tick();
    chk("bp_pops", RW'(pops_seen), RW'(8));
    chk("bp_valid", RW'(reqValid), RW'(1));
    grant = 1'b1;
    wait_idle("bp");
    chk("bp_total", RW'(pops_seen), RW'(12));

    // Zero-size request
    clr_stats();
    submit(1, 32'h4000, 0);
    wait_idle("size0");
    chk("size0_noreq", RW'(valids_seen), '0);
    chk("size0_nopop", RW'(pops_seen), '0);

    // Address wrap
    clr_stats();
    submit(0, 32'hFFFF_FFF8, 2);
    wait_idle("wrap");
    chk("wrap_reqs", RW'(valids_seen), RW'(2));

    // Back-to-back macro requests
    clr_stats();
    p0 = done_seen;
    submit(0, 32'h5000, 4);
    submit(1, 32'h6000, 3);
    wait_idle("b2b");
    chk("b2b_dones", RW'(done_seen - p0), RW'(2));
    chk("b2b_pu0", RW'(pops_pu[0]), RW'(4));
    chk("b2b_pu1", RW'(pops_pu[1]), RW'(3));

    // Randomized traffic with random stalls and grant
    rnd_mode = 1'b1;
    for (int it = 0; it < 15; it++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++)
        submit($urandom_range(0, NP - 1), AW'($urandom),
               $urandom_range(0, 16));
      wait_idle("rnd");
    end
    rnd_mode = 1'b0;
    grant = 1'b1;
    stall = '0;

    // Reset mid-operation discards all work
    grant = 1'b0;
    submit(1, 32'h7000, 10);
    repeat (4) tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("midrst");
    expq.delete();
    exp_done = done_seen;
    for (int p = 0; p < NP; p++) alloc[p] = rdp[p];
    @(negedge clk);
    rst = 1'b0;
    grant = 1'b1;
    tick();
    chk("midrst_ready", RW'(wr_ready), RW'(1));
    clr_stats();
    submit(1, 32'h8000, 5);
    wait_idle("postrst");
    chk("postrst_pops", RW'(pops_pu[1]), RW'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
